// File: rtl/fetch_unit.sv
// fetch_unit: IF-stage sequencer driving the PC register, instruction memory and IF/ID register.
// Four-state FSM (BOOT/REQ/HOLD/DROP) with a one-entry hold buffer and a pending-redirect register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr
);
  typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_t;
  state_t      state_q, state_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d, hold_instr_q, hold_instr_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] tgt, load_pc, load_instr;
  logic        load;
  assign imem_addr  = pc;
  assign tgt        = {redirect_pc[31:2], 2'b00};
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;
  always_comb begin
    state_d      = state_q;
    next_pc      = pc;
    pc_en        = 1'b0;
    imem_req     = 1'b0;
    load         = 1'b0;
    load_pc      = pc;
    load_instr   = imem_rdata;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pend_d       = pend_q;
    case (state_q)
      BOOT: begin
        pc_en   = 1'b1;
        next_pc = redirect_valid ? tgt : RESET_PC;
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect_valid) begin
            pc_en   = 1'b1;
            next_pc = tgt;
          end else if (!stall) begin
            pc_en   = 1'b1;
            next_pc = pc + 32'd4;
            load    = 1'b1;
          end else begin
            hold_pc_d    = pc;
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end
        end else if (redirect_valid) begin
          pend_d  = tgt;
          state_d = DROP;
        end
      end
      HOLD: begin
        load_pc    = hold_pc_q;
        load_instr = hold_instr_q;
        if (redirect_valid) begin
          pc_en   = 1'b1;
          next_pc = tgt;
          state_d = REQ;
        end else if (!stall) begin
          pc_en   = 1'b1;
          next_pc = hold_pc_q + 32'd4;
          load    = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        // outstanding request to the old pc must complete before the target can be fetched
        imem_req = 1'b1;
        if (redirect_valid) pend_d = tgt;
        if (imem_ready) begin
          pc_en   = 1'b1;
          next_pc = redirect_valid ? tgt : pend_q;
          state_d = REQ;
        end
      end
    endcase
    ifid_valid_d = redirect_valid ? 1'b0 : stall ? ifid_valid_q : load;
    ifid_pc_d    = load ? load_pc : ifid_pc_q;
    ifid_instr_d = redirect_valid ? NOP_INSTR : load ? load_instr : ifid_instr_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= BOOT;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
      pend_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      pend_q       <= pend_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a transaction-level fetch model.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clock = 1'b0, reset = 1'b0;
  logic [31:0] pc, next_pc, imem_addr, imem_rdata, redirect_pc, ifid_pc, ifid_instr, rd_xor;
  logic        pc_en, imem_req, imem_ready, stall, redirect_valid, ifid_valid;
  int          checks = 0, passes = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
  );

  always #5 clock = ~clock;
  assign imem_rdata = imem_addr ^ rd_xor;

  // stand-in for the programcounter register
  always @(posedge clock or negedge reset)
    if (!reset) pc <= 32'h0;
    else if (pc_en) pc <= next_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // model: boot flag, a queue holding at most one stalled instruction, a pending-redirect target
  logic        m_boot = 1'b1, m_drop = 1'b0, m_v = 1'b0;
  logic [31:0] m_pend = 32'h0, m_ipc = 32'h0, m_iin = NOP;
  logic [63:0] m_buf[$];
  logic        n_drop, n_v, n_push, n_pop;
  logic [31:0] n_pend, n_ipc, n_iin;
  logic [63:0] n_entry;

  always @(negedge clock) begin
    logic        boot, drop, v, hasb, ld, en;
    logic [31:0] ipc, iin, tgt, nxt, lpc, lin;
    boot = !reset || m_boot;
    drop = reset && m_drop;
    v    = reset && m_v;
    hasb = reset && (m_buf.size() != 0);
    ipc  = reset ? m_ipc : 32'h0;
    iin  = reset ? m_iin : NOP;
    tgt  = redirect_pc & ~32'h3;
    en = 1'b0; nxt = 32'h0; ld = 1'b0; lpc = 32'h0; lin = 32'h0;
    n_drop = drop; n_pend = m_pend; n_push = 1'b0; n_pop = 1'b0; n_entry = {pc, imem_rdata};
    if (boot) begin
      en = 1'b1; nxt = redirect_valid ? tgt : 32'h0;
    end else if (hasb) begin
      if (redirect_valid) begin en = 1'b1; nxt = tgt; n_pop = 1'b1; end
      else if (!stall) begin
        en = 1'b1; nxt = m_buf[0][63:32] + 32'd4; ld = 1'b1;
        lpc = m_buf[0][63:32]; lin = m_buf[0][31:0]; n_pop = 1'b1;
      end
    end else if (imem_ready) begin
      n_drop = 1'b0;
      if (drop) begin en = 1'b1; nxt = redirect_valid ? tgt : m_pend; end
      else if (redirect_valid) begin en = 1'b1; nxt = tgt; end
      else if (!stall) begin en = 1'b1; nxt = pc + 32'd4; ld = 1'b1; lpc = pc; lin = imem_rdata; end
      else n_push = 1'b1;
    end else if (redirect_valid) begin
      n_drop = 1'b1; n_pend = tgt;
    end
    chk("imem_req", imem_req, {31'b0, !boot && !hasb});
    chk("imem_addr", imem_addr, pc);
    chk("pc_en", pc_en, {31'b0, en});
    if (en) chk("next_pc", next_pc, nxt);
    chk("ifid_valid", ifid_valid, {31'b0, v});
    if (v || !reset) begin
      chk("ifid_pc", ifid_pc, ipc);
      chk("ifid_instr", ifid_instr, iin);
    end
    if (redirect_valid) begin n_v = 1'b0; n_ipc = ipc; n_iin = NOP; end
    else if (stall) begin n_v = v; n_ipc = ipc; n_iin = iin; end
    else if (ld) begin n_v = 1'b1; n_ipc = lpc; n_iin = lin; end
    else begin n_v = 1'b0; n_ipc = ipc; n_iin = iin; end
  end

  always @(posedge clock) begin
    if (!reset) begin
      m_boot = 1'b1; m_drop = 1'b0; m_pend = 32'h0; m_v = 1'b0; m_ipc = 32'h0; m_iin = NOP;
      m_buf.delete();
    end else begin
      m_boot = 1'b0; m_drop = n_drop; m_pend = n_pend; m_v = n_v; m_ipc = n_ipc; m_iin = n_iin;
      if (n_pop) void'(m_buf.pop_front());
      if (n_push) m_buf.push_back(n_entry);
    end
  end

  task automatic cyc(input logic rdy, input logic st, input logic rv, input logic [31:0] rpc);
    @(posedge clock); #1;
    imem_ready = rdy; stall = st; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  initial begin
    imem_ready = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; rd_xor = 32'hC0DE_0000;
    #12;
    chk("rst_valid", {31'b0, ifid_valid}, 0);
    chk("rst_pc", ifid_pc, 0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_en", {31'b0, pc_en}, 1);
    chk("rst_next", next_pc, 0);
    reset = 1; imem_ready = 1; #1;
    chk("boot_req", {31'b0, imem_req}, 0);
    cyc(1, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 1);
    chk("first_addr", imem_addr, 0);
    chk("first_valid", {31'b0, ifid_valid}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      chk("zw_pc", ifid_pc, 32'(i * 4));
      chk("zw_valid", {31'b0, ifid_valid}, 1);
    end
    cyc(0, 0, 0, 0);
    chk("zw_pc_c", ifid_pc, 32'hC);
    chk("zw_instr_c", ifid_instr, 32'hC0DE_000C);
    chk("lat_addr0", imem_addr, 32'h10);
    chk("lat_en0", {31'b0, pc_en}, 0);
    cyc(0, 0, 0, 0);
    chk("lat_addr1", imem_addr, 32'h10);
    chk("lat_en1", {31'b0, pc_en}, 0);
    chk("lat_bub1", {31'b0, ifid_valid}, 0);
    cyc(1, 0, 0, 0);
    chk("lat_addr2", imem_addr, 32'h10);
    chk("lat_en2", {31'b0, pc_en}, 1);
    chk("lat_next", next_pc, 32'h14);
    chk("lat_bub2", {31'b0, ifid_valid}, 0);
    cyc(1, 1, 0, 0);
    chk("lat_pc", ifid_pc, 32'h10);
    chk("lat_valid", {31'b0, ifid_valid}, 1);
    chk("stl_en0", {31'b0, pc_en}, 0);
    cyc(1, 1, 0, 0);
    chk("hold_req", {31'b0, imem_req}, 0);
    chk("hold_en", {31'b0, pc_en}, 0);
    chk("hold_ifid", ifid_pc, 32'h10);
    cyc(1, 0, 0, 0);
    chk("rel_en", {31'b0, pc_en}, 1);
    chk("rel_next", next_pc, 32'h18);
    chk("rel_ifid", ifid_pc, 32'h10);
    cyc(0, 0, 1, 32'h103);
    chk("rel_pc", ifid_pc, 32'h14);
    chk("rel_req_addr", imem_addr, 32'h18);
    chk("rel_req", {31'b0, imem_req}, 1);
    cyc(0, 0, 0, 0);
    chk("drop_valid", {31'b0, ifid_valid}, 0);
    chk("drop_nop", ifid_instr, NOP);
    chk("drop_addr", imem_addr, 32'h18);
    chk("drop_en", {31'b0, pc_en}, 0);
    cyc(1, 0, 0, 0);
    chk("drop_next", next_pc, 32'h100);
    chk("drop_en1", {31'b0, pc_en}, 1);
    cyc(1, 0, 0, 0);
    chk("tgt_addr", imem_addr, 32'h100);
    chk("tgt_bubble", {31'b0, ifid_valid}, 0);
    cyc(1, 1, 0, 0);
    chk("tgt_pc", ifid_pc, 32'h100);
    chk("tgt_valid", {31'b0, ifid_valid}, 1);
    cyc(1, 1, 1, 32'h200);
    chk("hr_req", {31'b0, imem_req}, 0);
    chk("hr_en", {31'b0, pc_en}, 1);
    chk("hr_next", next_pc, 32'h200);
    cyc(1, 0, 1, 32'hFFFF_FFFF);
    chk("hr_valid", {31'b0, ifid_valid}, 0);
    chk("hr_addr", imem_addr, 32'h200);
    chk("wrap_tgt", next_pc, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_next", next_pc, 32'h0);
    cyc(0, 0, 0, 0);
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    #1 reset = 0; #1;
    chk("mid_rst_req", {31'b0, imem_req}, 0);
    chk("mid_rst_en", {31'b0, pc_en}, 1);
    chk("mid_rst_next", next_pc, 32'h0);
    chk("mid_rst_valid", {31'b0, ifid_valid}, 0);
    imem_ready = 1; #1;
    chk("late_ready", {31'b0, imem_req}, 0);
    @(posedge clock); #1 reset = 1; #1;
    chk("reboot_req", {31'b0, imem_req}, 0);
    cyc(1, 0, 0, 0);
    chk("reboot_addr", imem_addr, 32'h0);
    chk("reboot_req1", {31'b0, imem_req}, 1);
    repeat (4000) begin
      @(posedge clock); #1;
      reset          = ($urandom_range(0, 199) != 0);
      imem_ready     = ($urandom_range(0, 2) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom;
      rd_xor         = $urandom;
    end
    @(posedge clock); #1;
    reset = 1; redirect_valid = 0; stall = 0;
    repeat (3) @(posedge clock);
    #1 $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
